// File: rtl/j1_uart_io_port_pkg.sv
// Shared constants for the j1 <-> buart I/O port.
//   J1_IO_STATUS / J1_IO_DATA : default I/O addresses of the two registers
//   STAT_* : bit positions inside the STATUS word
//   status_word() : packs the STATUS register image
package j1_uart_io_port_pkg;

  localparam logic [15:0] J1_IO_STATUS = 16'h1000;
  localparam logic [15:0] J1_IO_DATA   = 16'h1001;

  localparam int unsigned STAT_TXRDY  = 0;
  localparam int unsigned STAT_RXAV   = 1;
  localparam int unsigned STAT_TXDROP = 2;

  // {count[7:0], 5'b0, tx_drop, rx_avail, tx_ready}
  function automatic logic [15:0] status_word(input logic [7:0] cnt,
                                              input logic       drop,
                                              input logic       avail,
                                              input logic       rdy);
    logic [15:0] w;
    w              = '0;
    w[15:8]        = cnt;
    w[STAT_TXDROP] = drop;
    w[STAT_RXAV]   = avail;
    w[STAT_TXRDY]  = rdy;
    return w;
  endfunction

endpackage

// File: rtl/j1_uart_io_port_byte_fifo.sv
// Synchronous byte FIFO, 2**AW entries, show-ahead head on dout.
//   clk, reset (async, active-high)
//   push/din  : write din when not full
//   pop       : advance head when not empty
//   dout      : current head byte
//   full, empty, count[AW:0] (0..2**AW)
module j1_uart_io_port_byte_fifo #(
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam int unsigned DEPTH    = 1 << AW;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    full    = (count == FULL_CNT);
    empty   = (count == '0);
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    dout    = mem[rd_ptr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by count/pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/j1_uart_io_port.sv
// j1 I/O-bus responder for the buart.
//   clk, reset (async, active-high)
//   io_rd, io_wr, mem_addr[15:0], dout[15:0] : j1 I/O bus in
//   io_din[15:0]   : registered read data to j1 (1-cycle latency)
//   uart_wr        : 1-cycle transmit strobe to buart
//   uart_tx_data   : byte to transmit, held until next send
//   uart_busy      : buart transmitter busy
//   uart_valid, uart_rx_data : buart received byte
//   uart_rd        : 1-cycle ack to buart, consumes its byte
// Received bytes are queued in a FIFO; STATUS reports fill level and
// TX readiness, DATA reads pop the queue, DATA writes transmit.
module j1_uart_io_port
  import j1_uart_io_port_pkg::*;
#(
  parameter logic [15:0] ADDR_STATUS = J1_IO_STATUS,
  parameter logic [15:0] ADDR_DATA   = J1_IO_DATA,
  parameter int unsigned FIFO_AW     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [15:0] mem_addr,
  input  logic [15:0] dout,
  output logic [15:0] io_din,
  output logic        uart_wr,
  output logic [7:0]  uart_tx_data,
  input  logic        uart_busy,
  input  logic        uart_valid,
  input  logic [7:0]  uart_rx_data,
  output logic        uart_rd
);

  logic               ack_pend;
  logic               tx_drop;
  logic               tx_ready;
  logic               rd_status;
  logic               rd_data;
  logic               wr_status;
  logic               wr_data;
  logic               fifo_push;
  logic               fifo_pop;
  logic [7:0]         fifo_head;
  logic               fifo_full;
  logic               fifo_empty;
  logic [FIFO_AW:0]   fifo_count;
  logic [7:0]         count8;
  logic               unused_dout_hi;

  assign unused_dout_hi = ^dout[15:8];

  always_comb begin
    tx_ready  = ~uart_busy & ~uart_wr;
    rd_status = io_rd & (mem_addr == ADDR_STATUS);
    rd_data   = io_rd & (mem_addr == ADDR_DATA);
    wr_status = io_wr & (mem_addr == ADDR_STATUS);
    wr_data   = io_wr & (mem_addr == ADDR_DATA);
    // ack_pend blocks a second push of the same buart byte while the ack is in flight
    fifo_push = uart_valid & ~fifo_full & ~ack_pend;
    fifo_pop  = rd_data & ~fifo_empty;
    count8    = 8'(fifo_count);
  end

  j1_uart_io_port_byte_fifo #(
    .AW (FIFO_AW)
  ) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (uart_rx_data),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // The ack to buart is exactly the registered ack_pend flag.
  assign uart_rd = ack_pend;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      io_din       <= '0;
      uart_wr      <= 1'b0;
      uart_tx_data <= '0;
      ack_pend     <= 1'b0;
      tx_drop      <= 1'b0;
    end else begin
      ack_pend <= fifo_push;
      uart_wr  <= 1'b0;

      if (io_rd) begin
        if (rd_status)
          io_din <= status_word(count8, tx_drop, ~fifo_empty, tx_ready);
        else if (fifo_pop)
          io_din <= {8'h01, fifo_head};
        else
          io_din <= '0;
      end

      if (wr_data) begin
        if (tx_ready) begin
          uart_tx_data <= dout[7:0];
          uart_wr      <= 1'b1;
        end else begin
          tx_drop <= 1'b1;
        end
      end else if (wr_status) begin
        tx_drop <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_j1_uart_io_port.sv
// Directed self-checking bench for j1_uart_io_port (FIFO_AW=4).
// A tiny buart RX model presents queued bytes on uart_valid/uart_rx_data
// and advances when it sees uart_rd at a clock edge.
module tb_j1_uart_io_port;

  localparam logic [15:0] A_STATUS = 16'h1000;
  localparam logic [15:0] A_DATA   = 16'h1001;

  logic        clk;
  logic        reset;
  logic        io_rd;
  logic        io_wr;
  logic [15:0] mem_addr;
  logic [15:0] dout;
  logic [15:0] io_din;
  logic        uart_wr;
  logic [7:0]  uart_tx_data;
  logic        uart_busy;
  logic        uart_valid;
  logic [7:0]  uart_rx_data;
  logic        uart_rd;

  int vectors     = 0;
  int miscompares = 0;

  // buart RX model
  logic [7:0] rx_bytes [64];
  int         rx_wr     = 0;
  int         rx_rd     = 0;
  int         rd_pulses = 0;

  assign uart_valid   = (rx_rd != rx_wr);
  assign uart_rx_data = rx_bytes[rx_rd % 64];

  always @(posedge clk) begin
    if (uart_rd) begin
      rx_rd     <= rx_rd + 1;
      rd_pulses <= rd_pulses + 1;
    end
  end

  j1_uart_io_port #(
    .ADDR_STATUS (16'h1000),
    .ADDR_DATA   (16'h1001),
    .FIFO_AW     (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .io_rd        (io_rd),
    .io_wr        (io_wr),
    .mem_addr     (mem_addr),
    .dout         (dout),
    .io_din       (io_din),
    .uart_wr      (uart_wr),
    .uart_tx_data (uart_tx_data),
    .uart_busy    (uart_busy),
    .uart_valid   (uart_valid),
    .uart_rx_data (uart_rx_data),
    .uart_rd      (uart_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] b);
    rx_bytes[rx_wr % 64] = b;
    rx_wr++;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic io_read(input logic [15:0] addr, output logic [15:0] data);
    io_rd    = 1'b1;
    mem_addr = addr;
    @(posedge clk);
    @(negedge clk);
    io_rd    = 1'b0;
    mem_addr = 16'h0000;
    data     = io_din;
  endtask

  task automatic io_write(input logic [15:0] addr, input logic [15:0] d);
    io_wr    = 1'b1;
    mem_addr = addr;
    dout     = d;
    @(posedge clk);
    @(negedge clk);
    io_wr    = 1'b0;
    mem_addr = 16'h0000;
    dout     = 16'h0000;
  endtask

  initial begin
    logic [15:0] rd;
    int          base;

    reset     = 1'b1;
    io_rd     = 1'b0;
    io_wr     = 1'b0;
    mem_addr  = 16'h0000;
    dout      = 16'h0000;
    uart_busy = 1'b0;

    // reset state
    cycles(2);
    check("rst_io_din", io_din, 16'h0000);
    check("rst_uart_wr", {15'b0, uart_wr}, 16'h0000);
    check("rst_uart_rd", {15'b0, uart_rd}, 16'h0000);
    check("rst_tx_data", {8'b0, uart_tx_data}, 16'h0000);
    reset = 1'b0;
    io_read(A_STATUS, rd);
    check("rst_status", rd, 16'h0001);

    // three bytes: ack one cycle after each push
    base = rd_pulses;
    load(8'h41); load(8'h42); load(8'h43);
    for (int i = 0; i < 6; i++) begin
      cycles(1);
      check($sformatf("rx_ack_phase%0d", i), {15'b0, uart_rd}, (i % 2 == 0) ? 16'h0001 : 16'h0000);
    end
    cycles(3);
    check("rx_ack_count3", 16'(rd_pulses - base), 16'd3);
    io_read(A_STATUS, rd); check("status_cnt3", rd, 16'h0303);
    io_read(A_DATA, rd);   check("data_41", rd, 16'h0141);
    io_read(A_DATA, rd);   check("data_42", rd, 16'h0142);
    io_read(A_DATA, rd);   check("data_43", rd, 16'h0143);
    io_read(A_DATA, rd);   check("data_empty", rd, 16'h0000);

    // unmapped addresses leave FIFO alone
    load(8'h10); load(8'h11);
    cycles(6);
    io_read(16'h0000, rd); check("rd_addr_0000", rd, 16'h0000);
    io_read(16'h1002, rd); check("rd_addr_1002", rd, 16'h0000);
    io_read(A_STATUS, rd); check("status_cnt2", rd, 16'h0203);
    io_read(A_DATA, rd);   check("data_10", rd, 16'h0110);
    io_read(A_DATA, rd);   check("data_11", rd, 16'h0111);

    // simultaneous push and pop at count 5
    for (int i = 0; i < 5; i++) load(8'(8'h20 + i));
    cycles(12);
    io_read(A_STATUS, rd); check("status_cnt5", rd, 16'h0503);
    load(8'h25);
    io_read(A_DATA, rd);   check("pushpop_old_head", rd, 16'h0120);
    io_read(A_STATUS, rd); check("pushpop_cnt5", rd, 16'h0503);
    for (int i = 0; i < 5; i++) begin
      io_read(A_DATA, rd);
      check($sformatf("pushpop_order%0d", i), rd, 16'(16'h0121 + i));
    end

    // 17 bytes into a 16-deep FIFO: backpressure
    base = rd_pulses;
    for (int i = 0; i < 17; i++) load(8'(8'h50 + i));
    cycles(40);
    check("full_ack_count16", 16'(rd_pulses - base), 16'd16);
    io_read(A_STATUS, rd); check("status_full", rd, 16'h1003);
    check("byte17_still_valid", {15'b0, uart_valid}, 16'h0001);
    io_read(A_DATA, rd);   check("full_pop_head", rd, 16'h0150);
    check("no_push_in_pop_cycle", {15'b0, uart_rd}, 16'h0000);
    cycles(1);
    check("byte17_pushed_next", {15'b0, uart_rd}, 16'h0001);
    io_read(A_STATUS, rd); check("status_refull", rd, 16'h1003);
    for (int i = 0; i < 16; i++) begin
      io_read(A_DATA, rd);
      check($sformatf("full_drain%0d", i), rd, 16'(16'h0151 + i));
    end
    io_read(A_DATA, rd);   check("full_drain_empty", rd, 16'h0000);

    // transmit path
    io_write(A_DATA, 16'h1255);
    check("tx_strobe", {15'b0, uart_wr}, 16'h0001);
    check("tx_data_55", {8'b0, uart_tx_data}, 16'h0055);
    cycles(1);
    check("tx_strobe_1cyc", {15'b0, uart_wr}, 16'h0000);
    uart_busy = 1'b1;
    io_write(A_DATA, 16'h0077);
    check("tx_busy_no_strobe", {15'b0, uart_wr}, 16'h0000);
    check("tx_busy_data_held", {8'b0, uart_tx_data}, 16'h0055);
    io_read(A_STATUS, rd); check("status_txdrop", rd, 16'h0004);
    io_write(A_STATUS, 16'hFFFF);
    io_read(A_STATUS, rd); check("status_txdrop_clr", rd, 16'h0000);
    uart_busy = 1'b0;
    io_read(A_STATUS, rd); check("status_idle", rd, 16'h0001);

    // async reset mid-stream with 3 bytes queued
    load(8'h70); load(8'h71); load(8'h72);
    cycles(10);
    io_read(A_STATUS, rd); check("pre_reset_cnt3", rd, 16'h0303);
    #2 reset = 1'b1;
    #1 check("async_rst_io_din", io_din, 16'h0000);
    cycles(1);
    reset = 1'b0;
    io_read(A_STATUS, rd); check("post_reset_status", rd, 16'h0001);
    io_read(A_DATA, rd);   check("post_reset_data", rd, 16'h0000);

    // reset while ack pending: byte re-pushed exactly once
    load(8'h7A);
    cycles(1);
    check("ackpend_uart_rd", {15'b0, uart_rd}, 16'h0001);
    #2 reset = 1'b1;
    #1 check("ackpend_rst_uart_rd", {15'b0, uart_rd}, 16'h0000);
    cycles(1);
    reset = 1'b0;
    check("ackpend_byte_kept", {15'b0, uart_valid}, 16'h0001);
    cycles(1);
    check("ackpend_repush_ack", {15'b0, uart_rd}, 16'h0001);
    io_read(A_DATA, rd);   check("ackpend_data_7a", rd, 16'h017A);
    io_read(A_DATA, rd);   check("ackpend_single_push", rd, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
